// File: rtl/pmips_pkg.sv
// PMIPS controller shared definitions: opcodes, ALU ops, PC select,
// FSM states and the ID/EX control word.
package pmips_pkg;

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_AND    = 4'd2;
   localparam logic [3:0] OP_OR     = 4'd3;
   localparam logic [3:0] OP_SLT    = 4'd4;
   localparam logic [3:0] OP_ADDI   = 4'd5;
   localparam logic [3:0] OP_LW     = 4'd6;
   localparam logic [3:0] OP_SW     = 4'd7;
   localparam logic [3:0] OP_BEQ    = 4'd8;
   localparam logic [3:0] OP_J      = 4'd9;
   localparam logic [3:0] OP_NOP_LO = 4'd10;
   localparam logic [3:0] OP_NOP_HI = 4'd15;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   typedef enum logic [1:0] {
      S_RUN,
      S_HOLD,
      S_DRAIN,
      S_FLUSH
   } state_t;

   typedef struct packed {
      logic [1:0] pcctl;
      logic       regwrite;
      logic       regdst;
      logic       alusrc;
      logic [2:0] aluop;
      logic       branch;
      logic       jump;
      logic       memwrite;
      logic       memread;
      logic       memtoreg;
   } ctrl_t;

   function automatic logic is_xfer(input logic [3:0] op);
      return (op == OP_BEQ) || (op == OP_J);
   endfunction

endpackage

// File: rtl/pmips_decode.sv
// Combinational opcode-to-control-word decoder for PMIPS.
// Ports: opcode (in, 4) -> ctrl (out, ctrl_t control word).
module pmips_decode
   import pmips_pkg::*;
(
   input  logic [3:0] opcode,
   output ctrl_t      ctrl
);

   function automatic ctrl_t rtype(input logic [2:0] a);
      ctrl_t c;
      c          = '0;
      c.regwrite = 1'b1;
      c.regdst   = 1'b1;
      c.memtoreg = 1'b1;
      c.aluop    = a;
      return c;
   endfunction

   always_comb begin
      ctrl       = '0;
      ctrl.pcctl = PC_SEQ;
      unique case (opcode) inside
         OP_ADD: ctrl = rtype(ALU_ADD);
         OP_SUB: ctrl = rtype(ALU_SUB);
         OP_AND: ctrl = rtype(ALU_AND);
         OP_OR:  ctrl = rtype(ALU_OR);
         OP_SLT: ctrl = rtype(ALU_SLT);
         OP_ADDI: begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.aluop    = ALU_ADD;
         end
         OP_LW: begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.memread  = 1'b1;
            ctrl.aluop    = ALU_ADD;
         end
         OP_SW: begin
            ctrl.alusrc   = 1'b1;
            ctrl.memwrite = 1'b1;
            ctrl.aluop    = ALU_ADD;
         end
         OP_BEQ: begin
            ctrl.branch = 1'b1;
            ctrl.aluop  = ALU_SUB;
            ctrl.pcctl  = PC_BR;
         end
         OP_J: begin
            ctrl.jump  = 1'b1;
            ctrl.aluop = ALU_ADD;
            ctrl.pcctl = PC_JMP;
         end
         [OP_NOP_LO:OP_NOP_HI]: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/pmips_control.sv
// PMIPS main controller: ID decode plus branch/jump bubble FSM.
// Ports: clock, reset (async low), opcode, branch_taken in; control
// fields, Stall out; stall_count only with PMIPS_BUBBLE_COUNT_EN.
module pmips_control
   import pmips_pkg::*;
#(
   parameter int BR_HOLD = 2,
   parameter int CNT_W   = 16
)(
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic       branch_taken,
   output logic [1:0] PCControl,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrc,
   output logic [2:0] ALUOp,
   output logic       Branch,
   output logic       Jump,
   output logic       MemWrite,
   output logic       MemRead,
   output logic       MemtoReg,
   output logic       Stall
`ifdef PMIPS_BUBBLE_COUNT_EN
  ,output logic [CNT_W-1:0] stall_count
`endif
);

   localparam int HW = (BR_HOLD > 1) ? $clog2(BR_HOLD) : 1;

   if (BR_HOLD < 1 || CNT_W < 1) begin : g_bad_param
      $error("pmips_control: BR_HOLD and CNT_W must be >= 1");
   end

   state_t        state, state_n;
   logic [HW-1:0] hcnt, hcnt_n;
   ctrl_t         dec, ctrl;

   pmips_decode u_dec (
      .opcode (opcode),
      .ctrl   (dec)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_RUN;
         hcnt  <= '0;
      end else begin
         state <= state_n;
         hcnt  <= hcnt_n;
      end
   end

   // HOLD lasts BR_HOLD-1 cycles: leave when the count reaches zero.
   always_comb begin
      state_n = state;
      hcnt_n  = hcnt;
      unique case (state)
         S_RUN: begin
            if (is_xfer(opcode)) begin
               state_n = S_HOLD;
               hcnt_n  = HW'(BR_HOLD - 1);
            end
         end
         S_HOLD: begin
            if (hcnt != '0) hcnt_n = hcnt - HW'(1);
            if (hcnt <= HW'(1)) state_n = S_DRAIN;
         end
         S_DRAIN: state_n = branch_taken ? S_FLUSH : S_RUN;
         S_FLUSH: state_n = S_RUN;
      endcase
   end

   always_comb begin
      ctrl  = '0;
      Stall = 1'b0;
      unique case (state)
         S_RUN: begin
            ctrl  = dec;
            Stall = is_xfer(opcode);
         end
         S_HOLD:  Stall = 1'b1;
         S_DRAIN: Stall = 1'b0;
         S_FLUSH: Stall = 1'b0;
      endcase
   end

   assign PCControl = ctrl.pcctl;
   assign RegWrite  = ctrl.regwrite;
   assign RegDst    = ctrl.regdst;
   assign ALUSrc    = ctrl.alusrc;
   assign ALUOp     = ctrl.aluop;
   assign Branch    = ctrl.branch;
   assign Jump      = ctrl.jump;
   assign MemWrite  = ctrl.memwrite;
   assign MemRead   = ctrl.memread;
   assign MemtoReg  = ctrl.memtoreg;

`ifdef PMIPS_BUBBLE_COUNT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         stall_count <= '0;
      else if (state != S_RUN && stall_count != '1)
         stall_count <= stall_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_pmips_control.sv
// Scoreboard bench for pmips_control: a slot-schedule reference model
// queues expected outputs per cycle; a negedge monitor compares them.
module tb_pmips_control;

   localparam int BR_HOLD = 2;
   localparam int CW      = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] opcode = 4'd12;
   logic       branch_taken = 1'b0;
   logic [1:0] PCControl;
   logic       RegWrite, RegDst, ALUSrc;
   logic [2:0] ALUOp;
   logic       Branch, Jump, MemWrite, MemRead, MemtoReg, Stall;
`ifdef PMIPS_BUBBLE_COUNT_EN
   logic [CW-1:0] stall_count;
`endif

   pmips_control #(.BR_HOLD(BR_HOLD), .CNT_W(CW)) dut (
      .clock        (clock),
      .reset        (reset),
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .PCControl    (PCControl),
      .RegWrite     (RegWrite),
      .RegDst       (RegDst),
      .ALUSrc       (ALUSrc),
      .ALUOp        (ALUOp),
      .Branch       (Branch),
      .Jump         (Jump),
      .MemWrite     (MemWrite),
      .MemRead      (MemRead),
      .MemtoReg     (MemtoReg),
      .Stall        (Stall)
`ifdef PMIPS_BUBBLE_COUNT_EN
     ,.stall_count  (stall_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] pcc;
      logic       rw, rd, as;
      logic [2:0] alu;
      logic       br, jp, mw, mr, m2r, st;
      logic [7:0] sc;
      int         cyc;
   } exp_t;

   typedef enum {K_STALL, K_DRAIN, K_FLUSH} slot_e;

   exp_t  q[$];
   slot_e sched[$];
   int    bc = 0;
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   exp_t  me;

   function automatic exp_t ref_dec(input logic [3:0] op);
      exp_t e;
      e = '{default: '0};
      if (op <= 4'd4) begin
         e.rw = 1; e.rd = 1; e.m2r = 1; e.alu = op[2:0];
      end else if (op == 4'd5) begin
         e.rw = 1; e.as = 1; e.m2r = 1;
      end else if (op == 4'd6) begin
         e.rw = 1; e.as = 1; e.mr = 1;
      end else if (op == 4'd7) begin
         e.as = 1; e.mw = 1;
      end else if (op == 4'd8) begin
         e.br = 1; e.alu = 3'b001; e.pcc = 2'b01;
      end else if (op == 4'd9) begin
         e.jp = 1; e.pcc = 2'b10;
      end
      return e;
   endfunction

   task automatic step(input logic [3:0] op, input logic bt,
                       input logic rst);
      exp_t  e;
      slot_e s;
      @(posedge clock);
      #1;
      opcode = op;
      branch_taken = bt;
      reset = rst;
      cyc++;
      if (!rst) begin
         sched.delete();
         bc = 0;
      end
      if (sched.size() == 0) begin
         e = ref_dec(op);
         e.st = (op == 4'd8) || (op == 4'd9);
         if (e.st && rst) begin
            repeat (BR_HOLD - 1) sched.push_back(K_STALL);
            sched.push_back(K_DRAIN);
         end
         e.sc = 8'(bc);
      end else begin
         e = '{default: '0};
         e.sc = 8'(bc);
         s = sched.pop_front();
         e.st = (s == K_STALL);
         if (s == K_DRAIN && bt) sched.push_back(K_FLUSH);
         if (bc < (1 << CW) - 1) bc++;
      end
      e.cyc = cyc;
      q.push_back(e);
   endtask

   task automatic settle();
      while (sched.size() != 0) step(4'd12, 1'b0, 1'b1);
   endtask

   task automatic chk(input string n, input logic [7:0] a,
                      input logic [7:0] x, input int c);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s cycle %0d actual=%0h expected=%0h",
                  n, c, a, x);
      end
   endtask

   always @(negedge clock) begin
      if (q.size() > 0) begin
         me = q.pop_front();
         chk("PCControl", 8'(PCControl), 8'(me.pcc), me.cyc);
         chk("RegWrite",  8'(RegWrite),  8'(me.rw),  me.cyc);
         chk("RegDst",    8'(RegDst),    8'(me.rd),  me.cyc);
         chk("ALUSrc",    8'(ALUSrc),    8'(me.as),  me.cyc);
         chk("ALUOp",     8'(ALUOp),     8'(me.alu), me.cyc);
         chk("Branch",    8'(Branch),    8'(me.br),  me.cyc);
         chk("Jump",      8'(Jump),      8'(me.jp),  me.cyc);
         chk("MemWrite",  8'(MemWrite),  8'(me.mw),  me.cyc);
         chk("MemRead",   8'(MemRead),   8'(me.mr),  me.cyc);
         chk("MemtoReg",  8'(MemtoReg),  8'(me.m2r), me.cyc);
         chk("Stall",     8'(Stall),     8'(me.st),  me.cyc);
`ifdef PMIPS_BUBBLE_COUNT_EN
         chk("stall_count", stall_count, me.sc, me.cyc);
`endif
      end
   end

   initial begin
      // reset state
      repeat (3) step(4'd12, 1'b0, 1'b0);
      step(4'd12, 1'b0, 1'b1);

      // every opcode from RUN
      for (int op = 0; op < 16; op++) begin
         step(4'(op), 1'b0, 1'b1);
         settle();
      end

      // BEQ not taken
      step(4'd8, 1'b0, 1'b1);
      step(4'd12, 1'b1, 1'b1);
      step(4'd12, 1'b0, 1'b1);
      step(4'd0, 1'b0, 1'b1);

      // BEQ taken, counter from zero
      step(4'd12, 1'b0, 1'b0);
      step(4'd8, 1'b0, 1'b1);
      step(4'd8, 1'b1, 1'b1);
      step(4'd12, 1'b1, 1'b1);
      step(4'd0, 1'b1, 1'b1);
      step(4'd0, 1'b0, 1'b1);
      step(4'd0, 1'b0, 1'b1);

      // J with J held in IF/ID
      step(4'd9, 1'b0, 1'b1);
      step(4'd9, 1'b0, 1'b1);
      step(4'd9, 1'b1, 1'b1);
      step(4'd9, 1'b0, 1'b1);
      settle();

      // reset mid-transfer
      step(4'd8, 1'b0, 1'b1);
      step(4'd0, 1'b0, 1'b0);
      step(4'd8, 1'b1, 1'b0);
      step(4'd0, 1'b0, 1'b1);
      step(4'd0, 1'b0, 1'b1);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         step(4'($urandom_range(15)), 1'($urandom_range(1)),
              1'($urandom_range(80) != 0));
      end
      settle();

`ifdef PMIPS_BUBBLE_COUNT_EN
      // counter saturation
      step(4'd12, 1'b0, 1'b0);
      repeat (90) begin
         step(4'd8, 1'b0, 1'b1);
         step(4'd12, 1'b0, 1'b1);
         step(4'd12, 1'b1, 1'b1);
         step(4'd12, 1'b0, 1'b1);
      end
      step(4'd0, 1'b0, 1'b1);
      step(4'd0, 1'b0, 1'b1);
`endif

      repeat (3) @(posedge clock);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0",
                  q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
